dmem_responder: RTL

Data-memory slave on the data side of the RV32I multicycle core. It answers load/store requests from the execute/memory stage and returns load data that the MEM stage registers toward writeback. It handles byte, half-word and word accesses, with sign or zero extension on loads and byte-lane merging on stores. Read latency is configurable, and misaligned or out-of-range accesses are flagged with an error.

---
 rtl/dmem_responder.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Data-side load/store slave for the RV32I multicycle core: byte/half/word
// accesses with load extension, store lane merging, fault flagging and a
// configurable read latency.
//
// state | meaning
// IDLE  | nothing in flight, ready to accept a request
// WAIT  | request accepted, counting down the remaining latency
// RESP  | one-cycle response pulse on rsp_*, ready to accept the next request

module dmem_responder #(
    parameter int XLEN        = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_wr,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_err
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state;
    logic [2:0]      cnt;
    logic [XLEN-1:0] mem [DEPTH_WORDS];
    logic [XLEN-1:0] rd_word;
    logic            cap_wr;
    logic            cap_err;
    logic            cap_uns;
    logic [1:0]      cap_lane;
    logic [1:0]      cap_size;
    logic            accept;
    logic            fault;
    logic [AW-1:0]   widx;
    logic [3:0]      be;
    logic [XLEN-1:0] wdata_rep;

    assign req_ready = (state != WAIT);
    assign accept    = req_valid & req_ready;
    assign widx      = req_addr[AW+1:2];

    always_comb begin
        fault = 1'b0;
        case (req_size)
            2'b01:   fault = req_addr[0];
            2'b10:   fault = (req_addr[1:0] != 2'b00);
            2'b11:   fault = 1'b1;
            default: fault = 1'b0;
        endcase
        // any word-index bit above the array depth means out of range
        if ((req_addr[XLEN-1:2] >> AW) != '0)
            fault = 1'b1;
    end

    always_comb begin
        be        = 4'b0000;
        wdata_rep = req_wdata;
        case (req_size)
            2'b00: begin
                be        = 4'b0001 << req_addr[1:0];
                wdata_rep = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                be        = req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{req_wdata[15:0]}};
            end
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] word,
                                               input logic [1:0]      lane,
                                               input logic [1:0]      size,
                                               input logic            uns);
        logic [XLEN-1:0] sh;
        logic [7:0]      b;
        logic [15:0]     h;
        sh = word >> {lane, 3'b000};
        b  = sh[7:0];
        h  = lane[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   extend = uns ? {24'd0, b} : {{24{b[7]}}, b};
            2'b01:   extend = uns ? {16'd0, h} : {{16{h[15]}}, h};
            default: extend = word;
        endcase
    endfunction

    // Storage is not reset; stores commit on the acceptance edge.
    always_ff @(posedge clk) begin
        if (accept) begin
            rd_word <= mem[widx];
            if (req_wr && !fault) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i])
                        mem[widx][8*i +: 8] <= wdata_rep[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            cap_wr    <= 1'b0;
            cap_err   <= 1'b0;
            cap_uns   <= 1'b0;
            cap_lane  <= '0;
            cap_size  <= '0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            case (state)
                WAIT: begin
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd1) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= cap_err;
                        rsp_rdata <= (cap_wr || cap_err) ? '0
                                   : extend(rd_word, cap_lane, cap_size, cap_uns);
                    end
                end
                default: begin
                    state <= IDLE;
                    if (accept) begin
                        cap_wr   <= req_wr;
                        cap_err  <= fault;
                        cap_uns  <= req_unsigned;
                        cap_lane <= req_addr[1:0];
                        cap_size <= req_size;
                        if (LATENCY == 1) begin
                            // single-cycle path reads the array directly
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= fault;
                            rsp_rdata <= (req_wr || fault) ? '0
                                       : extend(mem[widx], req_addr[1:0], req_size, req_unsigned);
                        end else begin
                            state <= WAIT;
                            cnt   <= 3'(LATENCY - 1);
                        end
                    end
                end
            endcase
        end
    end
endmodule
